// File: rtl/bec_seq_pkg.sv
// Shared types and constants for the sm_bec_v3 sequencer.
// Optional watchdog is enabled by defining BEC_SEQ_TIMEOUT_EN.
package bec_seq_pkg;

  localparam int unsigned FW             = 163;
  localparam int unsigned NUM_OPS        = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS          = (FW + WORD_W - 1) / WORD_W;
  localparam int unsigned TOP_W          = FW - WORD_W * (WORDS - 1);
  localparam logic [31:0] TOP_MASK       = (32'd1 << TOP_W) - 32'd1;
  localparam int unsigned SEL_W          = 3;
  localparam int unsigned WIDX_W         = 3;
  localparam int unsigned OP_IDX_W       = $clog2(NUM_OPS);
  localparam int unsigned BIT_IDX_W      = $clog2(FW);
  localparam int unsigned TMO_W          = 16;
  localparam int unsigned TIMEOUT_CYCLES = 65535;

  localparam logic [SEL_W-1:0] KEY_SEL = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_PUSH,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [WIDX_W-1:0] widx;
    logic [WORD_W-1:0] data;
  } cfg_wr_t;

endpackage

// File: rtl/bec_word_bank.sv
// FW-bit field register: 32-bit word writes by index, or a full-width load.
module bec_word_bank
  import bec_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDX_W-1:0] wr_widx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              ld_en,
  input  logic [FW-1:0]     ld_data,
  output logic [FW-1:0]     q
);

  // Top word carries only TOP_W bits; out-of-range indices match nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld_en) begin
      q <= ld_data;
    end else if (wr_en) begin
      for (int w = 0; w < int'(WORDS) - 1; w++) begin
        if (wr_widx == WIDX_W'(w)) q[w*WORD_W +: WORD_W] <= wr_data;
      end
      if (wr_widx == WIDX_W'(WORDS - 1)) q[FW-1 -: TOP_W] <= TOP_W'(wr_data & TOP_MASK);
    end
  end

endmodule

// File: rtl/bec_seq_ctrl.sv
// Sequencer feeding operands and key bits to sm_bec_v3 and capturing its result.
// Define BEC_SEQ_TIMEOUT_EN to build the inactivity watchdog.
module bec_seq_ctrl
  import bec_seq_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [WIDX_W-1:0] cfg_widx,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              run_done,
  output logic              key_overrun,
  output logic              timeout_err,
  input  logic [WIDX_W-1:0] rd_widx,
  output logic [WORD_W-1:0] rd_data,
  output logic              enable,
  output logic              load_data,
  output logic [2:0]        load_status,
  output logic [FW-1:0]     data_out,
  input  logic              trigLoad,
  input  logic              next_key,
  output logic              ki,
  input  logic [3:0]        core_status,
  input  logic [FW-1:0]     data_in,
  input  logic              core_done
);

  state_e                 state, state_nxt;
  logic [OP_IDX_W-1:0]    op_idx, op_idx_nxt;
  logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic                   exhausted, exh_nxt;
  logic                   busy_nxt, enable_nxt, run_done_nxt, key_overrun_nxt;
  logic                   load_data_nxt, ki_nxt, cfg_ready_nxt;
  logic [2:0]             load_status_nxt;
  logic [FW-1:0]          data_out_nxt;
  logic                   res_ld_c, busy_state_c, abort_c, tmo_fire_c, cfg_fire_c;
  cfg_wr_t                cfg_wr;
  logic [FW-1:0]          ops [NUM_OPS];
  logic [FW-1:0]          key, result;
  logic                   unused_status;

  assign unused_status = ^core_status;
  assign cfg_wr        = '{sel: cfg_sel, widx: cfg_widx, data: cfg_data};
  assign cfg_fire_c    = cfg_valid && cfg_ready;
  assign busy_state_c  = (state == LOAD_WAIT) || (state == LOAD_PUSH) || (state == RUN);
  assign abort_c       = busy_state_c && (abort || tmo_fire_c);

  for (genvar i = 0; i < int'(NUM_OPS); i++) begin : g_op
    bec_word_bank u_op (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_i),
      .wr_en   (cfg_fire_c && (cfg_wr.sel == SEL_W'(i))),
      .wr_widx (cfg_wr.widx),
      .wr_data (cfg_wr.data),
      .ld_en   (1'b0),
      .ld_data ('0),
      .q       (ops[i])
    );
  end

  bec_word_bank u_key (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .wr_en   (cfg_fire_c && (cfg_wr.sel == KEY_SEL)),
    .wr_widx (cfg_wr.widx),
    .wr_data (cfg_wr.data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (key)
  );

  bec_word_bank u_res (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .wr_en   (1'b0),
    .wr_widx ('0),
    .wr_data ('0),
    .ld_en   (res_ld_c),
    .ld_data (data_in),
    .q       (result)
  );

  // Host read mux over the zero-padded result.
  always_comb begin
    logic [WORDS*WORD_W-1:0] res_pad;
    res_pad = (WORDS*WORD_W)'(result);
    rd_data = '0;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (rd_widx == WIDX_W'(w)) rd_data = res_pad[w*WORD_W +: WORD_W];
    end
  end

`ifdef BEC_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_err_nxt;

  // Inactivity counter restarts on any core handshake and idles at zero.
  always_comb begin
    tmo_cnt_nxt = (!busy_state_c || trigLoad || next_key) ? '0 : tmo_cnt + 1'b1;
    tmo_fire_c  = busy_state_c && !trigLoad && !next_key &&
                  (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    tmo_err_nxt = timeout_err;
    if ((state == IDLE || state == DONE) && start && !abort) tmo_err_nxt = 1'b0;
    if (tmo_fire_c) tmo_err_nxt = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt     <= tmo_cnt_nxt;
      timeout_err <= tmo_err_nxt;
    end
  end
`else
  assign tmo_fire_c  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt       = state;
    op_idx_nxt      = op_idx;
    bit_idx_nxt     = bit_idx;
    exh_nxt         = exhausted;
    busy_nxt        = busy;
    enable_nxt      = enable;
    run_done_nxt    = run_done;
    key_overrun_nxt = key_overrun;
    load_data_nxt   = 1'b0;
    ki_nxt          = 1'b0;
    res_ld_c        = 1'b0;
    data_out_nxt    = data_out;
    load_status_nxt = load_status;
    cfg_ready_nxt   = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_nxt       = LOAD_WAIT;
          run_done_nxt    = 1'b0;
          key_overrun_nxt = 1'b0;
          op_idx_nxt      = '0;
          bit_idx_nxt     = BIT_IDX_W'(FW - 1);
          exh_nxt         = 1'b0;
          busy_nxt        = 1'b1;
          enable_nxt      = 1'b1;
        end
      end
      LOAD_WAIT: begin
        if (trigLoad) begin
          state_nxt     = LOAD_PUSH;
          load_data_nxt = 1'b1;
        end
      end
      LOAD_PUSH: begin
        op_idx_nxt = op_idx + 1'b1;
        if (op_idx == OP_IDX_W'(NUM_OPS - 1)) begin
          state_nxt = RUN;
          ki_nxt    = key[bit_idx];
        end else begin
          state_nxt = LOAD_WAIT;
        end
      end
      RUN: begin
        ki_nxt = ki;
        // Completion takes priority over a coincident key request.
        if (core_done) begin
          res_ld_c     = 1'b1;
          enable_nxt   = 1'b0;
          busy_nxt     = 1'b0;
          run_done_nxt = 1'b1;
          state_nxt    = DONE;
          ki_nxt       = 1'b0;
        end else if (next_key) begin
          if (exhausted) begin
            key_overrun_nxt = 1'b1;
          end else if (bit_idx == '0) begin
            exh_nxt = 1'b1;
            ki_nxt  = 1'b0;
          end else begin
            bit_idx_nxt = bit_idx - 1'b1;
            ki_nxt      = key[bit_idx_nxt];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort_c) begin
      state_nxt     = IDLE;
      busy_nxt      = 1'b0;
      enable_nxt    = 1'b0;
      load_data_nxt = 1'b0;
      ki_nxt        = 1'b0;
      res_ld_c      = 1'b0;
    end

    if (state_nxt == LOAD_WAIT) begin
      data_out_nxt    = ops[op_idx_nxt];
      load_status_nxt = 3'(op_idx_nxt);
    end

    cfg_ready_nxt = (state_nxt == IDLE) || (state_nxt == DONE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state       <= IDLE;
      op_idx      <= '0;
      bit_idx     <= '0;
      exhausted   <= 1'b0;
      busy        <= 1'b0;
      enable      <= 1'b0;
      run_done    <= 1'b0;
      key_overrun <= 1'b0;
      load_data   <= 1'b0;
      ki          <= 1'b0;
      data_out    <= '0;
      load_status <= '0;
      cfg_ready   <= 1'b0;
    end else begin
      state       <= state_nxt;
      op_idx      <= op_idx_nxt;
      bit_idx     <= bit_idx_nxt;
      exhausted   <= exh_nxt;
      busy        <= busy_nxt;
      enable      <= enable_nxt;
      run_done    <= run_done_nxt;
      key_overrun <= key_overrun_nxt;
      load_data   <= load_data_nxt;
      ki          <= ki_nxt;
      data_out    <= data_out_nxt;
      load_status <= load_status_nxt;
      cfg_ready   <= cfg_ready_nxt;
    end
  end

endmodule
